// File: rtl/ov5640_pkg.sv
// ov5640_pkg: shared OV5640 sequencer state encoding and default 50 MHz delay constants
package ov5640_pkg;
  typedef enum logic [2:0] {
    WAIT_PWR,
    ACTIVE,
    WAIT_FRAME,
    RST_HOLD,
    PWDN_SETTLE,
    SLEEP,
    WAKE_RST,
    WAKE_SETTLE
  } slp_state_t;
  localparam int unsigned DLY_RST_HOLD     = 50_000;
  localparam int unsigned DLY_PWDN_SETTLE  = 50_000;
  localparam int unsigned DLY_WAKE_RST     = 100_000;
  localparam int unsigned DLY_WAKE_SETTLE  = 1_050_000;
  localparam int unsigned DLY_FRAME_TMO    = 2_500_000;
  localparam int unsigned DLY_CNT_W        = 22;
endpackage

// File: rtl/ov5640_sleep_ctrl.sv
// ov5640_sleep_ctrl: frame-aligned standby entry (RESETB low, then PWDN high) and datasheet-ordered wake for the OV5640; clk sclk, sync active-low s_rst_n, inputs power_done/cam_vsync/sleep_req/wake_req, registered outputs slp_pwdn/slp_resetb/cam_active/sleeping/busy/frame_timeout
module ov5640_sleep_ctrl
  import ov5640_pkg::*;
#(
  parameter int unsigned DELAY_RST_HOLD    = DLY_RST_HOLD,
  parameter int unsigned DELAY_PWDN_SETTLE = DLY_PWDN_SETTLE,
  parameter int unsigned DELAY_WAKE_RST    = DLY_WAKE_RST,
  parameter int unsigned DELAY_WAKE_SETTLE = DLY_WAKE_SETTLE,
  parameter int unsigned FRAME_TIMEOUT     = DLY_FRAME_TMO,
  parameter int unsigned CNT_W             = DLY_CNT_W
) (
  input  logic sclk,
  input  logic s_rst_n,
  input  logic power_done,
  input  logic cam_vsync,
  input  logic sleep_req,
  input  logic wake_req,
  output logic slp_pwdn,
  output logic slp_resetb,
  output logic cam_active,
  output logic sleeping,
  output logic busy,
  output logic frame_timeout
);
  slp_state_t state, state_n;
  logic [CNT_W-1:0] cnt;
  logic vsync_d, vs_rise, ft_n, counting;
  assign vs_rise = cam_vsync & ~vsync_d;
  assign counting = state inside {WAIT_FRAME, RST_HOLD, PWDN_SETTLE, WAKE_RST, WAKE_SETTLE};
  always_comb begin
    state_n = state;
    ft_n = frame_timeout;
    case (state)
      WAIT_PWR:    state_n = power_done ? ACTIVE : WAIT_PWR;
      ACTIVE:      if (sleep_req) begin
        state_n = WAIT_FRAME;
        ft_n = 1'b0;
      end
      WAIT_FRAME:  if (vs_rise) state_n = RST_HOLD;
                   else if (cnt == CNT_W'(FRAME_TIMEOUT - 1)) begin
                     state_n = RST_HOLD;
                     ft_n = 1'b1;
                   end
      RST_HOLD:    state_n = (cnt == CNT_W'(DELAY_RST_HOLD - 1)) ? PWDN_SETTLE : RST_HOLD;
      PWDN_SETTLE: state_n = (cnt == CNT_W'(DELAY_PWDN_SETTLE - 1)) ? SLEEP : PWDN_SETTLE;
      SLEEP:       state_n = wake_req ? WAKE_RST : SLEEP;
      WAKE_RST:    state_n = (cnt == CNT_W'(DELAY_WAKE_RST - 1)) ? WAKE_SETTLE : WAKE_RST;
      WAKE_SETTLE: state_n = (cnt == CNT_W'(DELAY_WAKE_SETTLE - 1)) ? ACTIVE : WAKE_SETTLE;
      default:     state_n = WAIT_PWR;
    endcase
    if (!power_done && state != WAIT_PWR) begin
      state_n = WAIT_PWR;
      ft_n = frame_timeout;
    end
  end
  always_ff @(posedge sclk) begin
    if (!s_rst_n) begin
      state <= WAIT_PWR;
      cnt <= '0;
      vsync_d <= 1'b0;
      slp_pwdn <= 1'b0;
      slp_resetb <= 1'b1;
      cam_active <= 1'b0;
      sleeping <= 1'b0;
      busy <= 1'b0;
      frame_timeout <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= (state_n != state || !counting) ? '0 : cnt + 1'b1;
      vsync_d <= cam_vsync;
      slp_pwdn <= state_n inside {PWDN_SETTLE, SLEEP};
      slp_resetb <= !(state_n inside {RST_HOLD, PWDN_SETTLE, SLEEP, WAKE_RST});
      cam_active <= state_n == ACTIVE;
      sleeping <= state_n == SLEEP;
      busy <= state_n inside {WAIT_FRAME, RST_HOLD, PWDN_SETTLE, WAKE_RST, WAKE_SETTLE};
      frame_timeout <= ft_n;
    end
  end
endmodule

// File: tb/tb_ov5640_sleep_ctrl.sv
// tb_ov5640_sleep_ctrl: timeline-model checker plus directed literal checks for ov5640_sleep_ctrl
module tb_ov5640_sleep_ctrl;
  localparam int RH = 4, PS = 3, WR = 5, WS = 6, TO = 20;
  logic sclk = 0, s_rst_n = 0, power_done = 0, cam_vsync = 0, sleep_req = 0, wake_req = 0;
  logic slp_pwdn, slp_resetb, cam_active, sleeping, busy, frame_timeout;
  int vectors = 0, miscompares = 0, cyc = 0;
  bit run = 0;
  int mode = 0, k = 0, fe = -1;
  bit ft = 0, pv = 0;
  ov5640_sleep_ctrl #(
    .DELAY_RST_HOLD(RH), .DELAY_PWDN_SETTLE(PS), .DELAY_WAKE_RST(WR),
    .DELAY_WAKE_SETTLE(WS), .FRAME_TIMEOUT(TO), .CNT_W(22)
  ) dut (
    .sclk(sclk), .s_rst_n(s_rst_n), .power_done(power_done), .cam_vsync(cam_vsync),
    .sleep_req(sleep_req), .wake_req(wake_req), .slp_pwdn(slp_pwdn), .slp_resetb(slp_resetb),
    .cam_active(cam_active), .sleeping(sleeping), .busy(busy), .frame_timeout(frame_timeout)
  );
  always #5 sclk = ~sclk;
  task automatic cmp(input string nm, input logic act, input logic exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0b expected %0b at cycle %0d", nm, act, exp, cyc);
    end
  endtask
  task automatic step(input int n);
    repeat (n) @(negedge sclk);
  endtask
  // mode: 0 powered-off wait, 1 usable, 2 going to sleep, 3 asleep, 4 waking
  // k counts cycles since the sequence started; fe is the length of the frame wait once known
  always @(posedge sclk) begin
    cyc++;
    if (!s_rst_n) begin
      mode = 0; ft = 0; k = 0; fe = -1;
    end else if (!power_done && mode != 0) mode = 0;
    else case (mode)
      0: if (power_done) mode = 1;
      1: if (sleep_req) begin mode = 2; k = 0; fe = -1; ft = 0; end
      2: begin
        if (fe < 0) begin
          if (cam_vsync && !pv) fe = k + 1;
          else if (k == TO - 1) begin fe = TO; ft = 1; end
        end
        k++;
        if (fe >= 0 && k == fe + RH + PS) mode = 3;
      end
      3: if (wake_req) begin mode = 4; k = 0; end
      default: begin
        k++;
        if (k == WR + WS) mode = 1;
      end
    endcase
    pv = s_rst_n ? cam_vsync : 1'b0;
  end
  always @(negedge sclk) if (run) begin
    cmp("busy", busy, mode == 2 || mode == 4);
    cmp("cam_active", cam_active, mode == 1);
    cmp("sleeping", sleeping, mode == 3);
    cmp("slp_pwdn", slp_pwdn, mode == 3 || (mode == 2 && fe >= 0 && k >= fe + RH));
    cmp("slp_resetb", slp_resetb, !(mode == 3 || (mode == 2 && fe >= 0 && k >= fe) || (mode == 4 && k < WR)));
    cmp("frame_timeout", frame_timeout, ft);
  end
  task automatic pulse_sleep();
    sleep_req = 1; step(1); sleep_req = 0;
  endtask
  initial begin
    step(2);
    run = 1;
    cmp("rst_cam_active", cam_active, 0);
    cmp("rst_resetb", slp_resetb, 1);
    cmp("rst_pwdn", slp_pwdn, 0);
    cmp("rst_busy", busy, 0);
    cmp("rst_ft", frame_timeout, 0);
    s_rst_n = 1;
    for (int i = 0; i < 10; i++) begin step(1); cmp("gate_hold_cam", cam_active, 0); end
    power_done = 1; step(1);
    cmp("gate_cam_on", cam_active, 1);
    wake_req = 1; step(1); wake_req = 0;
    cmp("drop_wake_cam", cam_active, 1);
    cmp("drop_wake_busy", busy, 0);
    pulse_sleep();
    cmp("sleep_busy", busy, 1);
    cmp("sleep_cam_off", cam_active, 0);
    step(6); cam_vsync = 1; step(1); cam_vsync = 0;
    cmp("norm_resetb_fall", slp_resetb, 0);
    step(3); cmp("norm_pwdn_still0", slp_pwdn, 0);
    step(1); cmp("norm_pwdn_rise", slp_pwdn, 1);
    step(2); cmp("norm_sleep_still0", sleeping, 0);
    step(1); cmp("norm_sleeping", sleeping, 1);
    cmp("norm_ft", frame_timeout, 0);
    wake_req = 1; sleep_req = 1; step(1); wake_req = 0; sleep_req = 0;
    cmp("wake_busy", busy, 1);
    cmp("wake_pwdn0", slp_pwdn, 0);
    cmp("wake_not_sleeping", sleeping, 0);
    step(4); cmp("wake_resetb_still0", slp_resetb, 0);
    step(1); cmp("wake_resetb_rise", slp_resetb, 1);
    pulse_sleep();
    step(4); cmp("wake_cam_still0", cam_active, 0);
    step(1); cmp("wake_cam_on", cam_active, 1);
    pulse_sleep();
    step(19); cmp("tmo_resetb_still1", slp_resetb, 1);
    step(1); cmp("tmo_resetb_fall", slp_resetb, 0);
    cmp("tmo_ft", frame_timeout, 1);
    step(6); cmp("tmo_sleep_still0", sleeping, 0);
    step(1); cmp("tmo_sleeping", sleeping, 1);
    power_done = 0; step(1);
    cmp("pdrop_sleeping", sleeping, 0);
    cmp("pdrop_pwdn", slp_pwdn, 0);
    cmp("pdrop_resetb", slp_resetb, 1);
    cmp("pdrop_ft_kept", frame_timeout, 1);
    power_done = 1; step(1);
    cmp("pdrop_cam_back", cam_active, 1);
    sleep_req = 1; wake_req = 1; step(1); sleep_req = 0; wake_req = 0;
    cmp("both_busy", busy, 1);
    cmp("both_ft_clear", frame_timeout, 0);
    cam_vsync = 1; step(1); cam_vsync = 0;
    cmp("first_cycle_edge", slp_resetb, 0);
    step(4); cmp("abort_pre_pwdn", slp_pwdn, 1);
    s_rst_n = 0; step(1);
    cmp("abort_pwdn", slp_pwdn, 0);
    cmp("abort_resetb", slp_resetb, 1);
    cmp("abort_busy", busy, 0);
    s_rst_n = 1; step(1);
    cmp("abort_cam_back", cam_active, 1);
    pulse_sleep();
    step(19); cam_vsync = 1; step(1); cam_vsync = 0;
    cmp("coincide_resetb", slp_resetb, 0);
    cmp("coincide_ft", frame_timeout, 0);
    step(10);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/ov5640_sleep_ctrl.md
# ov5640_sleep_ctrl

Runtime power-down and wake sequencer for the OV5640 camera, used after the power-up sequence has completed. On request it waits for a frame boundary, drives the sensor into hardware standby (reset, then PWDN), and reports sleep. On a wake request it replays the datasheet release order (PWDN low, then RESETB high, then settle) and reports the camera usable again. It sits between the power-up controller and the SCCB configuration master. After a wake, the SCCB master must re-run the register configuration.

## Interface
Parameters:
- DELAY_RST_HOLD, 50_000: cycles RESETB is held low before PWDN rises (1 ms at 50 MHz).
- DELAY_PWDN_SETTLE, 50_000: cycles after PWDN rises before sleep is reported (1 ms).
- DELAY_WAKE_RST, 100_000: cycles with PWDN low and RESETB low before RESETB is released (2 ms).
- DELAY_WAKE_SETTLE, 1_050_000: cycles after RESETB release before the camera is active (21 ms).
- FRAME_TIMEOUT, 2_500_000: maximum cycles spent waiting for a VSYNC rising edge (50 ms).
- CNT_W, 22: width of the shared delay counter. It must satisfy 2^CNT_W > every delay parameter.

Ports:
- sclk, in, 1: 50 MHz system clock.
- s_rst_n, in, 1: synchronous, active-low reset.
- power_done, in, 1: power-up sequence complete.
- cam_vsync, in, 1: camera VSYNC, already synchronized to sclk upstream.
- sleep_req, in, 1: single-cycle request to enter standby.
- wake_req, in, 1: single-cycle request to leave standby.
- slp_pwdn, out, 1: PWDN contribution, ORed with the power-up controller's PWDN at top level.
- slp_resetb, out, 1: RESETB contribution, ANDed with the power-up controller's RESETB at top level.
- cam_active, out, 1: camera powered and out of reset. The SCCB master and capture path may run.
- sleeping, out, 1: camera in standby.
- busy, out, 1: a sequence is in progress.
- frame_timeout, out, 1: sticky flag; the last sleep entry was forced by timeout rather than a VSYNC edge.

## Operation
- Moore FSM. All outputs are registered and decoded from the state.
- States: WAIT_PWR, ACTIVE, WAIT_FRAME, RST_HOLD, PWDN_SETTLE, SLEEP, WAKE_RST, WAKE_SETTLE.
- WAIT_PWR: leave for ACTIVE when power_done=1.
- ACTIVE: on sleep_req, clear frame_timeout and go to WAIT_FRAME.
- WAIT_FRAME: go to RST_HOLD on a VSYNC rising edge (cam_vsync=1 and the previous sample=0). If cnt reaches FRAME_TIMEOUT-1 first, set frame_timeout and go to RST_HOLD.
- RST_HOLD: go to PWDN_SETTLE after DELAY_RST_HOLD cycles.
- PWDN_SETTLE: go to SLEEP after DELAY_PWDN_SETTLE cycles.
- SLEEP: on wake_req, go to WAKE_RST.
- WAKE_RST: go to WAKE_SETTLE after DELAY_WAKE_RST cycles.
- WAKE_SETTLE: go to ACTIVE after DELAY_WAKE_SETTLE cycles.
- Output values per state:
  - slp_resetb=0 in RST_HOLD, PWDN_SETTLE, SLEEP and WAKE_RST; 1 elsewhere.
  - slp_pwdn=1 in PWDN_SETTLE and SLEEP; 0 elsewhere.
  - cam_active=1 only in ACTIVE; sleeping=1 only in SLEEP.
  - busy=1 in WAIT_FRAME, RST_HOLD, PWDN_SETTLE, WAKE_RST and WAKE_SETTLE.
- Request handling:
  - sleep_req is honoured only in ACTIVE; wake_req only in SLEEP.
  - Requests in any other state are dropped, not queued.
  - If both requests assert in the same cycle, only the one valid for the current state acts.
- power_done=0 in any state other than WAIT_PWR forces WAIT_PWR on the next edge, with all outputs at reset values except frame_timeout, which holds.

## Timing
- Reset values: state=WAIT_PWR, cnt=0, slp_pwdn=0, slp_resetb=1, cam_active=0, sleeping=0, busy=0, frame_timeout=0, vsync_d=0.
- The delay counter is shared. It clears on every state change and increments by 1 per cycle in delay states. A delay state therefore lasts exactly D cycles (exit when cnt==D-1).
- Request-to-output latency:
  - sleep_req at edge N → busy=1 and cam_active=0 at edge N+1.
  - wake_req at edge N → busy=1 at N+1, and slp_pwdn=0 from N+1.
- Frame wait:
  - A VSYNC edge seen in the first WAIT_FRAME cycle counts.
  - A VSYNC edge coinciding with the timeout cycle takes the edge path, so frame_timeout is not set.
- Total wake time: DELAY_WAKE_RST + DELAY_WAKE_SETTLE cycles from the SLEEP exit to cam_active=1.
- Reset asserted mid-sequence returns the block to reset values on the next edge; no partial sequence completes.

## Structure
- Shared package ov5640_pkg holds:
  - the state enum, also reused by the SCCB init master for status decode;
  - the default 50 MHz delay constants, as shared by the power-up controller.
- No sub-module is needed. Edge detect, the counter and the FSM live in one module.

## Test plan
All scenarios use DELAY_RST_HOLD=4, DELAY_PWDN_SETTLE=3, DELAY_WAKE_RST=5, DELAY_WAKE_SETTLE=6, FRAME_TIMEOUT=20.
- Power gate: power_done held 0 for 10 cycles, then 1 → cam_active=0 throughout the hold, then 1 on the edge after power_done rises.
- Normal sleep: sleep_req, then a VSYNC rise 7 cycles later → slp_resetb falls the edge after the VSYNC rise. slp_pwdn rises 4 cycles later, sleeping rises 3 cycles after that, and frame_timeout=0.
- Timeout: sleep_req with VSYNC held low → slp_resetb falls 20 cycles after WAIT_FRAME entry and frame_timeout=1.
- Wake: wake_req in SLEEP → slp_pwdn=0 next cycle, slp_resetb=1 after 5 cycles, cam_active=1 after a further 6 cycles.
- Dropped requests: wake_req in ACTIVE, and sleep_req during WAKE_SETTLE → no state change and unchanged timing. Simultaneous sleep_req and wake_req in ACTIVE → sleep sequence starts.
- Abort: s_rst_n low in PWDN_SETTLE → slp_pwdn=0, slp_resetb=1, busy=0 on the next edge. Separately, power_done dropping in SLEEP → WAIT_PWR with frame_timeout retained.
